// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin write-side scheduler for a shared generic_fifo. NREQ producers
// compete for the FIFO's single write port; the winner's word is registered
// onto fifo_in/fifo_write. An internal level counter tracks the words already
// committed to the FIFO (including the one sitting in the write register), so
// a word is never issued into a full FIFO.
//
// Ports
//   clk         clock, all logic on posedge
//   reset       asynchronous, active-high reset
//   req_valid   per-requester "word pending"
//   req_data    per-requester word, requester i at slice i
//   req_lock    per-requester burst-lock request
//   req_ack     one-hot combinational accept for the current cycle
//   fifo_in     registered write data to the FIFO
//   fifo_write  registered write strobe to the FIFO
//   fifo_read   monitored copy of the consumer's FIFO read
//   level       committed word count, including the pending write
//   grant_id    index of the last acked requester
//
// Build option
//   FIFO_WRITE_ARB_LOCK_EN  when defined, a requester acked with req_lock=1
//                           owns the write port until it releases the lock or
//                           drops req_valid. When undefined, req_lock is ignored
//                           and arbitration is pure per-word round-robin.
//
// state | meaning
// ------+------------------------------------------------------------------
// ARB   | normal round-robin arbitration over all valid requesters
// LOCK  | burst lock; only the owner (the last granted requester) is eligible
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int MSB   = 3,
    parameter int LSB   = 0,
    parameter int DEPTH = 4,
    localparam int W    = MSB - LSB + 1,
    localparam int LW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_data,
    input  logic [NREQ-1:0]     req_lock,
    output logic [NREQ-1:0]     req_ack,
    output logic [W-1:0]        fifo_in,
    output logic                fifo_write,
    input  logic                fifo_read,
    output logic [LW-1:0]       level,
    output logic [IW-1:0]       grant_id
);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;          // last granted requester; search starts at ptr+1
    logic [NREQ-1:0] eligible;
    logic [IW-1:0]   win;
    logic            found;
    logic            has_room;
    logic            issue;
    logic            rd_dec;
    logic [LW-1:0]   level_next;

    always_comb begin
        eligible = req_valid;
`ifdef FIFO_WRITE_ARB_LOCK_EN
        // While locked, the pointer always holds the owner.
        if (state == LOCK) begin
            eligible = req_valid & (NREQ'(1) << ptr);
        end
`endif
    end

    // First eligible requester after the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && eligible[IW'((int'(ptr) + k) % NREQ)]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // The issue decision deliberately ignores a same-cycle read: level already
    // counts the word in the write register, and crediting a read here would
    // let a full FIFO accept a word one cycle too early.
    assign has_room = (level < LW'(DEPTH));
    assign issue    = found && has_room;
    assign req_ack  = (issue && !reset) ? (NREQ'(1) << win) : '0;

    assign rd_dec = fifo_read && (level != '0);

    always_comb begin
        level_next = level;
        if (issue && !rd_dec) begin
            level_next = level + LW'(1);
        end else if (!issue && rd_dec) begin
            level_next = level - LW'(1);
        end
    end

`ifndef FIFO_WRITE_ARB_LOCK_EN
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            ptr        <= IW'(NREQ - 1);
            level      <= '0;
            fifo_write <= 1'b0;
            fifo_in    <= '0;
            grant_id   <= '0;
        end else begin
            fifo_write <= issue;
            level      <= level_next;
            if (issue) begin
                fifo_in  <= req_data[int'(win)*W +: W];
                grant_id <= win;
                ptr      <= win;
            end
`ifdef FIFO_WRITE_ARB_LOCK_EN
            case (state)
                ARB: begin
                    if (issue && req_lock[win]) begin
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    // Pointer stays on the owner, so arbitration resumes at owner+1.
                    if (!req_valid[ptr]) begin
                        state <= ARB;
                    end else if (issue && !req_lock[win]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
`else
            state <= ARB;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int MSB   = 3;
    localparam int LSB   = 0;
    localparam int DEPTH = 4;
    localparam int W     = MSB - LSB + 1;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(NREQ);

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_data;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ-1:0]     req_ack;
    logic [W-1:0]        fifo_in;
    logic                fifo_write;
    logic                fifo_read;
    logic [LW-1:0]       level;
    logic [IW-1:0]       grant_id;

    fifo_write_arbiter #(.NREQ(NREQ), .MSB(MSB), .LSB(LSB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ack    (req_ack),
        .fifo_in    (fifo_in),
        .fifo_write (fifo_write),
        .fifo_read  (fifo_read),
        .level      (level),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: occupancy as a plain integer, last winner, lock flag.
    int       m_level;
    int       m_last;
    bit       m_lock;
    bit       m_fw;
    int       m_fin;
    int       m_gid;
    int       acked;
    logic [NREQ-1:0] dut_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_last  = NREQ - 1;
        m_lock  = 0;
        m_fw    = 0;
        m_fin   = 0;
        m_gid   = 0;
    endtask

    task automatic new_word(input int i);
        req_data[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    endtask

    // One clock: predict the winner from the current inputs, compare the
    // combinational ack, advance the model across the edge, compare the
    // registered outputs.
    task automatic step();
        int w;
        int idx;
        int dec;
        #1;
        w = -1;
        if (m_level < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (w < 0 && req_valid[idx] && (!m_lock || idx == m_last)) w = idx;
            end
        end
        dut_ack = req_ack;
        check("req_ack", 32'(req_ack), (w >= 0) ? (32'd1 << w) : 32'd0);
`ifdef FIFO_WRITE_ARB_LOCK_EN
        if (m_lock) begin
            if (!req_valid[m_last]) m_lock = 0;
            else if (w >= 0 && !req_lock[w]) m_lock = 0;
        end else if (w >= 0 && req_lock[w]) begin
            m_lock = 1;
        end
`endif
        dec = (fifo_read && m_level != 0) ? 1 : 0;
        if (w >= 0) begin
            m_fw   = 1;
            m_fin  = int'(req_data[w*W +: W]);
            m_gid  = w;
            m_last = w;
        end else begin
            m_fw = 0;
        end
        m_level = m_level + ((w >= 0) ? 1 : 0) - dec;
        acked = w;
        @(posedge clk);
        #1;
        check("fifo_write", 32'(fifo_write), 32'(m_fw));
        check("fifo_in", 32'(fifo_in), 32'(m_fin));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("level", 32'(level), 32'(m_level));
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        fifo_read = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        fifo_read = 1'b0;
        model_reset();
        acked = -1;

        // Reset state, with all requesters pending: no ack may leak out.
        repeat (2) @(posedge clk);
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = W'(i + 5);
        #1;
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_write", 32'(fifo_write), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_fifo_in", 32'(fifo_in), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // All requesters valid: acks 0,1,2,3 then FIFO full.
        for (int k = 0; k < NREQ; k++) begin
            step();
            check("ack_seq", 32'(dut_ack), 32'd1 << k);
            check("fill_level", 32'(level), 32'(k + 1));
            if (acked >= 0) new_word(acked);
        end
        step();
        check("full_noack", 32'(dut_ack), 32'd0);
        check("full_write_low", 32'(fifo_write), 32'd0);

        // Full FIFO with a read pulse: no credit for the same-cycle read.
        req_valid = 4'b0010;
        fifo_read = 1'b1;
        step();
        check("full_read_noack", 32'(dut_ack), 32'd0);
        check("full_read_level", 32'(level), 32'd3);
        fifo_read = 1'b0;
        step();
        check("after_read_ack", 32'(dut_ack), 32'b0010);
        check("after_read_level", 32'(level), 32'd4);

        // Drain to 2, then issue and read together.
        req_valid = '0;
        fifo_read = 1'b1;
        step();
        step();
        req_valid = 4'b0001;
        step();
        check("issue_read_level", 32'(level), 32'd2);
        check("issue_read_write", 32'(fifo_write), 32'd1);

        // Drain to 0, then reads at empty must not underflow.
        req_valid = '0;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("empty_read_level", 32'(level), 32'd0);
        end
        fifo_read = 1'b0;

`ifdef FIFO_WRITE_ARB_LOCK_EN
        // Requester 2 takes a burst lock while 0 and 3 are also waiting.
        apply_reset();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1101;
        req_lock  = 4'b0100;
        fifo_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("lock_ack", 32'(dut_ack), 32'b0100);
            new_word(2);
        end
        req_lock = 4'b0000;
        step();
        check("unlock_ack", 32'(dut_ack), 32'b0100);
        step();
        check("post_lock_ack", 32'(dut_ack), 32'b1000);
        fifo_read = 1'b0;
`endif

        // Randomized traffic with requesters holding words until acked.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            step();
            if (acked >= 0) begin
                if ($urandom_range(0, 1) == 0) req_valid[acked] = 1'b0;
                else new_word(acked);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    new_word(i);
                end
            end
            req_lock  = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
            fifo_read = ($urandom_range(0, 2) == 0);
        end

        // Reset one cycle after an ack discards the pending write.
        apply_reset();
        req_valid = 4'b1111;
        step();
        check("pre_rst_write", 32'(fifo_write), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_write", 32'(fifo_write), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_ack", 32'(req_ack), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_write", 32'(fifo_write), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_ack", 32'(dut_ack), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
